// File: rtl/bist_march_ctrl.sv
// March C- memory BIST controller.
// Reports each newly faulty repair block once; flags overflow past the spare count.
module bist_march_ctrl #(
    parameter int ADDR_W          = 16,
    parameter int BLOCK_W         = 7,
    parameter int MAX_FAULT_BLOCK = 25,
    parameter int RD_LATENCY      = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BIST_EN,
    output logic        BIST_PASS,
    output logic [15:0] NEED_REPAIR_ADDR,
    output logic        BIST_DONE,
    output logic        BIST_FAIL,
    output logic [4:0]  FAULT_COUNT,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_CE,
    output logic        MEM_CSB,
    output logic        MEM_WEB,
    output logic        MEM_OEB,
    output logic [7:0]  MEM_IDATA,
    input  logic [7:0]  MEM_RDATA
);

    localparam int NB = 1 << (ADDR_W - BLOCK_W);
    localparam int WL = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [1:0] WAIT_LAST = 2'(WL);
    localparam logic [4:0] CNT_MAX = 5'(MAX_FAULT_BLOCK);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WR, S_RD, S_WAIT, S_CMP, S_DONE
    } state_t;

    state_t              state, nxt_state;
    logic [2:0]          elem, nxt_elem;
    logic [ADDR_W-1:0]   addr, nxt_addr;
    logic [1:0]          wcnt;
    logic [NB-1:0]       bitmap;
    logic                down;
    logic [ADDR_W-1:0]   last_addr;
    logic [7:0]          exp_rd;
    logic [7:0]          nxt_wdata;
    logic [ADDR_W-BLOCK_W-1:0] blk;

    // M3/M4 walk downwards; reads expect the previous element's write value
    assign down      = (elem == 3'd3) || (elem == 3'd4);
    assign last_addr = down ? '0 : A_MAX;
    assign exp_rd    = (elem == 3'd2 || elem == 3'd4) ? 8'hFF : 8'h00;
    assign nxt_wdata = (nxt_elem == 3'd1 || nxt_elem == 3'd3) ? 8'hFF : 8'h00;
    assign blk       = addr[ADDR_W-1:BLOCK_W];

    always_comb begin
        nxt_state = state;
        nxt_elem  = elem;
        nxt_addr  = addr;
        case (state)
            S_IDLE, S_DONE: begin
                if (START)
                    nxt_state = S_INIT;
            end
            S_INIT: begin
                nxt_state = S_WR;
                nxt_elem  = 3'd0;
                nxt_addr  = '0;
            end
            S_WR: begin
                if (addr == A_MAX) begin
                    nxt_state = S_RD;
                    nxt_elem  = 3'd1;
                    nxt_addr  = '0;
                end else begin
                    nxt_addr = addr + A_ONE;
                end
            end
            S_RD: begin
                nxt_state = (RD_LATENCY > 1) ? S_WAIT : S_CMP;
            end
            S_WAIT: begin
                if (wcnt == WAIT_LAST)
                    nxt_state = S_CMP;
            end
            S_CMP: begin
                if (addr == last_addr) begin
                    if (elem == 3'd5) begin
                        nxt_state = S_DONE;
                    end else begin
                        nxt_state = S_RD;
                        nxt_elem  = elem + 3'd1;
                        nxt_addr  = (elem == 3'd2 || elem == 3'd3) ? A_MAX : '0;
                    end
                end else begin
                    nxt_state = S_RD;
                    nxt_addr  = down ? addr - A_ONE : addr + A_ONE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= S_IDLE;
            elem             <= '0;
            addr             <= '0;
            wcnt             <= '0;
            bitmap           <= '0;
            BIST_EN          <= 1'b0;
            BIST_PASS        <= 1'b0;
            NEED_REPAIR_ADDR <= '0;
            BIST_DONE        <= 1'b0;
            BIST_FAIL        <= 1'b0;
            FAULT_COUNT      <= '0;
            MEM_ADDR         <= '0;
            MEM_CE           <= 1'b0;
            MEM_CSB          <= 1'b1;
            MEM_WEB          <= 1'b1;
            MEM_OEB          <= 1'b1;
            MEM_IDATA        <= '0;
        end else begin
            state     <= nxt_state;
            elem      <= nxt_elem;
            addr      <= nxt_addr;
            wcnt      <= (state == S_WAIT) ? wcnt + 2'd1 : 2'd0;
            BIST_EN   <= !(nxt_state == S_IDLE || nxt_state == S_DONE);
            BIST_DONE <= (nxt_state == S_DONE);
            BIST_PASS <= 1'b0;
            MEM_ADDR  <= 16'(nxt_addr);
            MEM_CE    <= 1'b0;
            MEM_CSB   <= 1'b1;
            MEM_WEB   <= 1'b1;
            MEM_OEB   <= 1'b1;
            case (nxt_state)
                S_WR: begin
                    MEM_CE    <= 1'b1;
                    MEM_CSB   <= 1'b0;
                    MEM_WEB   <= 1'b0;
                    MEM_IDATA <= nxt_wdata;
                end
                S_RD: begin
                    MEM_CE  <= 1'b1;
                    MEM_CSB <= 1'b0;
                    MEM_OEB <= 1'b0;
                end
                S_CMP: begin
                    if (nxt_elem != 3'd5) begin
                        MEM_CE    <= 1'b1;
                        MEM_CSB   <= 1'b0;
                        MEM_WEB   <= 1'b0;
                        MEM_IDATA <= nxt_wdata;
                    end
                end
                default: ;
            endcase
            if (nxt_state == S_INIT) begin
                bitmap      <= '0;
                FAULT_COUNT <= '0;
                BIST_FAIL   <= 1'b0;
            end
            // Reporting never stalls the march; overflow only sets the sticky flag
            if (state == S_CMP && MEM_RDATA != exp_rd && !bitmap[blk]) begin
                if (FAULT_COUNT < CNT_MAX) begin
                    BIST_PASS        <= 1'b1;
                    NEED_REPAIR_ADDR <= 16'(addr);
                    bitmap[blk]      <= 1'b1;
                    FAULT_COUNT      <= FAULT_COUNT + 5'd1;
                end else begin
                    BIST_FAIL <= 1'b1;
                end
            end
        end
    end

endmodule
